// File: rtl/fbw_pkg.sv
// fbw_pkg: shared types and default geometry for the framebuffer writer.
//   fbw_state_t  - flush FSM states
//   fbw_entry_t  - one buffered pixel write {addr, color}
//   FBW_*        - default framebuffer geometry and address width
package fbw_pkg;

  localparam int FBW_FB_W   = 320;
  localparam int FBW_FB_H   = 240;
  localparam int FBW_ADDR_W = 17;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } fbw_state_t;

  // Address field is sized by FBW_ADDR_W; the top truncates to its ADDR_W.
  typedef struct packed {
    logic [FBW_ADDR_W-1:0] addr;
    logic [7:0]            color;
  } fbw_entry_t;

endpackage

// File: rtl/fbw_fifo.sv
// fbw_fifo: synchronous pixel FIFO with registered pointers and occupancy.
//   ACLK, reset (async, active-high)
//   push/din  - enqueue request; dropped when full unless a pop happens too
//   pop       - dequeue request (ignored when empty)
//   dout      - head entry, forced to zero while empty
//   empty, full, count - occupancy status
module fbw_fifo
  import fbw_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          ACLK,
  input  logic          reset,
  input  logic          push,
  input  fbw_entry_t    din,
  input  logic          pop,
  output fbw_entry_t    dout,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  fbw_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same edge frees the slot, so push-while-full is fine then.
  assign do_push = push && (!full || do_pop);

  // Zero while empty so the downstream address/data are clean after reset.
  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge ACLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge ACLK or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/framebuffer_writer.sv
// framebuffer_writer: turns (x, y, colour) pixels into linear framebuffer
// write requests, buffers them in a FIFO and reports when a frame drains.
//   ACLK, reset (async, active-high)
//   xAddr, yAddr, pix_color, Write - pixel input, one per cycle, no ready
//   frame_done    - end-of-render pulse, starts the flush
//   stall         - upstream must stop writing (covers the stage-1 entry)
//   mem_addr/mem_data/mem_valid/mem_ready - write request handshake
//   frame_flushed - one-cycle pulse once everything has been handed off
//   overflow      - sticky, a pixel was dropped into a full FIFO
//   clip_count    - out-of-range pixels discarded (saturating)
// Build option: define FBW_CLIP_EN to discard pixels outside FB_W x FB_H
// and count them; otherwise addresses are the plain truncated product.
module framebuffer_writer
  import fbw_pkg::*;
#(
  parameter int FB_W       = FBW_FB_W,
  parameter int FB_H       = FBW_FB_H,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = FBW_ADDR_W
) (
  input  logic              ACLK,
  input  logic              reset,
  input  logic [15:0]       xAddr,
  input  logic [15:0]       yAddr,
  input  logic              Write,
  input  logic [7:0]        pix_color,
  input  logic              frame_done,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              frame_flushed,
  output logic              overflow,
  output logic [15:0]       clip_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   lin;
  logic          in_range, s1_acc, s1_vld, pop;
  fbw_entry_t    s1_q, head;
  logic          fifo_empty, fifo_full;
  logic [CW-1:0] fifo_count;
  fbw_state_t    state, state_nxt;
  logic          drain_nxt;

  // ---------------- stage 1: address generation ----------------
  assign lin = 32'(yAddr) * 32'(FB_W) + 32'(xAddr);

`ifdef FBW_CLIP_EN
  logic [15:0] clip_q;

  assign in_range = (32'(xAddr) < 32'(FB_W)) && (32'(yAddr) < 32'(FB_H));

  always_ff @(posedge ACLK or posedge reset) begin
    if (reset)                                      clip_q <= '0;
    else if (Write && !in_range && clip_q != 16'hFFFF) clip_q <= clip_q + 16'd1;
  end

  assign clip_count = clip_q;
`else
  assign in_range   = 1'b1;
  assign clip_count = '0;
`endif

  assign s1_acc = Write && in_range;

  always_ff @(posedge ACLK or posedge reset) begin
    if (reset) begin
      s1_vld <= 1'b0;
      s1_q   <= '0;
    end else begin
      s1_vld <= s1_acc;
      if (s1_acc) begin
        s1_q.addr  <= FBW_ADDR_W'(ADDR_W'(lin));
        s1_q.color <= pix_color;
      end
    end
  end

  // ---------------- buffer and memory side ----------------
  assign pop = mem_valid && mem_ready;

  fbw_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .ACLK  (ACLK),
    .reset (reset),
    .push  (s1_vld),
    .din   (s1_q),
    .pop   (pop),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Combinational from registers only, so reset drops it immediately.
  assign mem_valid = !fifo_empty;
  assign mem_addr  = ADDR_W'(head.addr);
  assign mem_data  = head.color;

  // One slot of headroom for the pixel already sitting in stage 1.
  assign stall = (fifo_count >= CW'(FIFO_DEPTH - 1));

  always_ff @(posedge ACLK or posedge reset) begin
    if (reset)                             overflow <= 1'b0;
    else if (s1_vld && fifo_full && !pop)  overflow <= 1'b1;
  end

  // ---------------- flush FSM ----------------
  // Lookahead: leave FLUSH on the edge that empties the pipeline, so DONE
  // is entered exactly when stage 1 and the FIFO are both empty.
  assign drain_nxt = !s1_acc && !s1_vld &&
                     (fifo_empty || (fifo_count == CW'(1) && pop));

  always_ff @(posedge ACLK or posedge reset) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    frame_flushed = 1'b0;
    case (state)
      ST_RUN:   if (frame_done) state_nxt = ST_FLUSH;
      ST_FLUSH: if (drain_nxt)  state_nxt = ST_DONE;
      ST_DONE: begin
        frame_flushed = 1'b1;
        state_nxt     = ST_RUN;
      end
      default:  state_nxt = ST_RUN;
    endcase
  end

endmodule

// File: tb/tb_framebuffer_writer.sv
module tb_framebuffer_writer;

  localparam int FB_W   = 320;
  localparam int FB_H   = 240;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 17;
`ifdef FBW_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic              ACLK = 1'b0;
  logic              reset;
  logic [15:0]       xAddr, yAddr;
  logic              Write;
  logic [7:0]        pix_color;
  logic              frame_done;
  logic              stall;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_valid;
  logic              mem_ready;
  logic              frame_flushed;
  logic              overflow;
  logic [15:0]       clip_count;

  framebuffer_writer #(.FB_W(FB_W), .FB_H(FB_H), .FIFO_DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .ACLK(ACLK), .reset(reset), .xAddr(xAddr), .yAddr(yAddr), .Write(Write),
    .pix_color(pix_color), .frame_done(frame_done), .stall(stall),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .frame_flushed(frame_flushed), .overflow(overflow),
    .clip_count(clip_count)
  );

  always #5 ACLK = ~ACLK;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int last_hs = -1;
  int fl_cnt = 0;
  int fl_cyc = -1;
  bit track = 1'b1;
  int q_addr[$];
  int q_data[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_in_range(input int x, input int y);
    return !CLIP || (x < FB_W && y < FB_H);
  endfunction

  // Called at a negedge with inputs already driven: score the request
  // that will be handed off at the coming edge, log the new pixel, advance.
  task automatic tick();
    int ea, ed;
    if (mem_valid && mem_ready) begin
      hs_cnt++;
      last_hs = cyc;
      if (track) begin
        tests++;
        assert (q_addr.size() != 0) else begin
          fails++;
          $error("FAIL spurious_req: observed addr %0d expected no request", mem_addr);
        end
        if (q_addr.size() != 0) begin
          ea = q_addr.pop_front();
          ed = q_data.pop_front();
          chk("req_addr", 32'(mem_addr), 32'(ea));
          chk("req_data", 32'(mem_data), 32'(ed));
        end
      end
    end
    if (frame_flushed) begin
      fl_cnt++;
      fl_cyc = cyc;
    end
    if (Write && track && model_in_range(int'(xAddr), int'(yAddr))) begin
      q_addr.push_back((int'(yAddr) * FB_W + int'(xAddr)) % (1 << ADDR_W));
      q_data.push_back(int'(pix_color));
    end
    @(posedge ACLK);
    @(negedge ACLK);
    cyc++;
  endtask

  task automatic put(input int x, input int y, input int c);
    Write = 1'b1;
    xAddr = 16'(x);
    yAddr = 16'(y);
    pix_color = 8'(c);
  endtask

  task automatic put_rand();
    put(int'($urandom_range(FB_W - 1)), int'($urandom_range(FB_H - 1)), int'($urandom_range(255)));
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && q_addr.size() != 0; i++) tick();
    chk("drain_empty", 32'(q_addr.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, h0;
    reset = 1'b1; Write = 1'b0; xAddr = '0; yAddr = '0; pix_color = '0;
    frame_done = 1'b0; mem_ready = 1'b0;
    @(negedge ACLK); @(negedge ACLK);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_flushed", 32'(frame_flushed), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_clip_count", 32'(clip_count), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_data", 32'(mem_data), 32'd0);
    reset = 1'b0;
    tick();

    // single pixel latency and address
    mem_ready = 1'b1;
    put(3, 2, 8'hA5);
    tick();
    Write = 1'b0;
    chk("lat_valid_c1", 32'(mem_valid), 32'd0);
    tick();
    chk("lat_valid_c2", 32'(mem_valid), 32'd1);
    chk("lat_addr", 32'(mem_addr), 32'd643);
    chk("lat_data", 32'(mem_data), 32'hA5);
    tick();
    chk("lat_valid_c3", 32'(mem_valid), 32'd0);

    // 20 writes obeying stall, memory blocked first
    mem_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && !stall; i++) begin
      put_rand();
      n++;
      tick();
    end
    Write = 1'b0;
    chk("stall_writes", 32'(n), 32'd8);
    chk("stall_at_7", 32'(stall), 32'd1);
    tick(); tick(); tick();
    chk("stall_held", 32'(stall), 32'd1);
    chk("stall_no_ovf", 32'(overflow), 32'd0);
    mem_ready = 1'b1;
    for (int i = 0; i < 200 && n < 20; i++) begin
      if (!stall) begin
        put_rand();
        n++;
      end else Write = 1'b0;
      tick();
    end
    Write = 1'b0;
    chk("burst_count", 32'(n), 32'd20);
    drain(60);
    chk("burst_no_ovf", 32'(overflow), 32'd0);

    // random traffic with random back-pressure
    for (int i = 0; i < 300; i++) begin
      mem_ready = ($urandom_range(3) != 0);
      if (!stall && $urandom_range(1) == 1) put_rand();
      else Write = 1'b0;
      tick();
    end
    Write = 1'b0;
    mem_ready = 1'b1;
    drain(60);
    chk("rand_no_ovf", 32'(overflow), 32'd0);

    // frame_done with an empty pipeline
    tick(); tick();
    fl_cnt = 0;
    frame_done = 1'b1;
    k = cyc;
    tick();
    frame_done = 1'b0;
    tick(); tick(); tick();
    chk("empty_flush_cnt", 32'(fl_cnt), 32'd1);
    chk("empty_flush_cyc", 32'(fl_cyc), 32'(k + 2));

    // 4 buffered, frame_done (repeated while flushing), then drain
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put_rand();
      tick();
    end
    Write = 1'b0;
    tick(); tick();
    fl_cnt = 0;
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    tick();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    tick();
    chk("flush_wait", 32'(fl_cnt), 32'd0);
    mem_ready = 1'b1;
    drain(20);
    tick(); tick(); tick(); tick();
    chk("flush_cnt", 32'(fl_cnt), 32'd1);
    chk("flush_cyc", 32'(fl_cyc), 32'(last_hs + 1));

    // out-of-range coordinates
    h0 = hs_cnt;
    put(320, 0, 8'h11);
    tick();
    put(0, 240, 8'h22);
    tick();
    Write = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    drain(10);
    chk("clip_count", 32'(clip_count), CLIP ? 32'd2 : 32'd0);
    chk("clip_reqs", 32'(hs_cnt - h0), CLIP ? 32'd0 : 32'd2);

    // reset with 5 entries buffered
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      put_rand();
      tick();
    end
    Write = 1'b0;
    tick(); tick();
    chk("pre_rst_valid", 32'(mem_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_async_valid", 32'(mem_valid), 32'd0);
    chk("rst_async_addr", 32'(mem_addr), 32'd0);
    q_addr.delete();
    q_data.delete();
    tick();
    reset = 1'b0;
    mem_ready = 1'b1;
    h0 = hs_cnt;
    for (int i = 0; i < 6; i++) tick();
    chk("post_rst_reqs", 32'(hs_cnt - h0), 32'd0);
    fl_cnt = 0;
    frame_done = 1'b1;
    k = cyc;
    tick();
    frame_done = 1'b0;
    tick(); tick(); tick();
    chk("post_rst_run", 32'(fl_cyc), 32'(k + 2));
    chk("post_rst_flcnt", 32'(fl_cnt), 32'd1);

    // writes ignoring stall: 9th pixel dropped
    track = 1'b0;
    mem_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      put_rand();
      tick();
    end
    Write = 1'b0;
    chk("ovf_before_drop", 32'(overflow), 32'd0);
    tick();
    chk("ovf_set", 32'(overflow), 32'd1);
    mem_ready = 1'b1;
    h0 = hs_cnt;
    for (int i = 0; i < 12; i++) tick();
    chk("ovf_drained", 32'(hs_cnt - h0), 32'd8);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("ovf_cleared", 32'(overflow), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
